scalar_alu_mc: RTL and testbench

SCALAR_ALU_MC -- requirements
Module: scalar_alu_mc

---
 rtl/scalar_alu_mc.sv | 254 +++++++++++++++++++++++++
 tb/tb_scalar_alu_mc.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scalar_alu_mc.sv
// scalar_alu_mc: scalar ALU with 1-cycle ops and an optional iterative MUL/DIV unit.
// Define SCALAR_ALU_MULDIV_EN to build the shift-add multiplier / restoring divider.
module scalar_alu_mc #(
    parameter int XLEN   = 64,
    parameter int PC_LEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   rs1,
    input  logic [XLEN-1:0]   rs2,
    input  logic [XLEN-1:0]   imm,
    input  logic [PC_LEN-1:0] pc,
    input  logic [3:0]        alu_signal,
    input  logic [3:0]        func_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   result,
    output logic [1:0]        sign_bits,
    output logic              illegal
);

    localparam logic [3:0] CL_NOP      = 4'd0;
    localparam logic [3:0] CL_BIN      = 4'd1;
    localparam logic [3:0] CL_BIN_W    = 4'd2;
    localparam logic [3:0] CL_IMM_BIN  = 4'd3;
    localparam logic [3:0] CL_IMM_BINW = 4'd4;
    localparam logic [3:0] CL_BRANCH   = 4'd5;
    localparam logic [3:0] CL_MEM_ADDR = 4'd6;
    localparam logic [3:0] CL_PC_BASED = 4'd7;
    localparam logic [3:0] CL_IMM      = 4'd8;

    localparam logic [3:0] F_ADD  = 4'd0;
    localparam logic [3:0] F_SUB  = 4'd1;
    localparam logic [3:0] F_ADDI = 4'd0;
    localparam logic [3:0] F_SLTI = 4'd1;

    localparam logic [1:0] SGN_ZERO = 2'b00;
    localparam logic [1:0] SGN_POS  = 2'b01;
    localparam logic [1:0] SGN_NEG  = 2'b10;

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] w);
        return XLEN'($signed(w));
    endfunction

    function automatic logic [1:0] sign_of(input logic [XLEN-1:0] v);
        if (v[XLEN-1]) return SGN_NEG;
        if (v == '0) return SGN_ZERO;
        return SGN_POS;
    endfunction

    state_t            state, state_d;
    logic [XLEN-1:0]   dec_res, result_d, md_res;
    logic              dec_ill, dec_calc, md_done;
    logic              illegal_d, out_valid_d, in_ready_d;
    logic [1:0]        sign_d;
    logic [31:0]       w_sum, w_diff, w_isum;

    assign w_sum  = rs1[31:0] + rs2[31:0];
    assign w_diff = rs1[31:0] - rs2[31:0];
    assign w_isum = rs1[31:0] + imm[31:0];

`ifdef SCALAR_ALU_MULDIV_EN
    localparam logic [3:0] CL_MULDIV = 4'd9;
    localparam logic [3:0] F_MUL  = 4'd0;
    localparam logic [3:0] F_MULH = 4'd1;
    localparam logic [3:0] F_DIV  = 4'd2;
    localparam logic [3:0] F_DIVU = 4'd3;
    localparam logic [3:0] F_REM  = 4'd4;
    localparam logic [3:0] F_REMU = 4'd5;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam int unsigned CW = $clog2(XLEN);

    logic [2*XLEN-1:0] work, work_nx, prod;
    logic [XLEN-1:0]   opnd, q_fix, r_fix, div_diff, load_a, load_b;
    logic [XLEN:0]     mul_sum, div_sh;
    logic [CW-1:0]     cnt;
    logic [3:0]        md_func;
    logic              md_neg, md_is_mul, div_ge, op_signed, load_neg;

    assign op_signed = (func_code == F_MUL) || (func_code == F_MULH) ||
                       (func_code == F_DIV) || (func_code == F_REM);
    assign load_a    = (op_signed && rs1[XLEN-1]) ? -rs1 : rs1;
    assign load_b    = (op_signed && rs2[XLEN-1]) ? -rs2 : rs2;
    assign load_neg  = (func_code == F_REM) ? rs1[XLEN-1] :
                       (op_signed && (rs1[XLEN-1] ^ rs2[XLEN-1]));

    // One iteration: shift-add multiply or restoring-divide step on magnitudes.
    assign md_is_mul = (md_func == F_MUL) || (md_func == F_MULH);
    assign mul_sum   = {1'b0, work[2*XLEN-1:XLEN]} + (work[0] ? {1'b0, opnd} : '0);
    assign div_sh    = work[2*XLEN-1:XLEN-1];
    assign div_ge    = div_sh >= {1'b0, opnd};
    assign div_diff  = div_sh[XLEN-1:0] - opnd;
    assign work_nx   = md_is_mul ? {mul_sum, work[XLEN-1:1]}
                                 : {div_ge ? div_diff : div_sh[XLEN-1:0], work[XLEN-2:0], div_ge};

    // Sign fix-up is folded into the last iteration so the result lands on time.
    assign prod    = md_neg ? -work_nx : work_nx;
    assign q_fix   = md_neg ? -work_nx[XLEN-1:0] : work_nx[XLEN-1:0];
    assign r_fix   = md_neg ? -work_nx[2*XLEN-1:XLEN] : work_nx[2*XLEN-1:XLEN];
    assign md_done = (cnt == CW'(XLEN-1));

    always_comb begin
        case (md_func)
            F_MUL:        md_res = prod[XLEN-1:0];
            F_MULH:       md_res = prod[2*XLEN-1:XLEN];
            F_DIV, F_DIVU: md_res = q_fix;
            default:      md_res = r_fix;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work    <= '0;
            opnd    <= '0;
            cnt     <= '0;
            md_func <= '0;
            md_neg  <= 1'b0;
        end else if (state == IDLE && in_valid && !flush && dec_calc) begin
            work    <= {{XLEN{1'b0}}, load_a};
            opnd    <= load_b;
            cnt     <= '0;
            md_func <= func_code;
            md_neg  <= load_neg;
        end else if (state == CALC) begin
            work <= work_nx;
            cnt  <= cnt + 1'b1;
        end
    end
`else
    assign md_done = 1'b1;
    assign md_res  = '0;
`endif

    // Single-cycle decode and compute.
    always_comb begin
        dec_res  = '0;
        dec_ill  = 1'b0;
        dec_calc = 1'b0;
        case (alu_signal)
            CL_NOP: dec_res = '0;
            CL_BIN: begin
                case (func_code)
                    F_ADD:   dec_res = rs1 + rs2;
                    F_SUB:   dec_res = rs1 - rs2;
                    default: dec_ill = 1'b1;
                endcase
            end
            CL_BIN_W: begin
                case (func_code)
                    F_ADD:   dec_res = sext32(w_sum);
                    F_SUB:   dec_res = sext32(w_diff);
                    default: dec_ill = 1'b1;
                endcase
            end
            CL_IMM_BIN: begin
                case (func_code)
                    F_ADDI:  dec_res = rs1 + imm;
                    F_SLTI:  dec_res = XLEN'($signed(rs1) < $signed(imm));
                    default: dec_ill = 1'b1;
                endcase
            end
            CL_IMM_BINW: begin
                case (func_code)
                    F_ADDI:  dec_res = sext32(w_isum);
                    F_SLTI:  dec_res = XLEN'($signed(rs1[31:0]) < $signed(imm[31:0]));
                    default: dec_ill = 1'b1;
                endcase
            end
            CL_BRANCH:   dec_res = rs1 - rs2;
            CL_MEM_ADDR: dec_res = rs1 + imm;
            CL_PC_BASED: dec_res = XLEN'(pc) + imm;
            CL_IMM:      dec_res = imm;
`ifdef SCALAR_ALU_MULDIV_EN
            CL_MULDIV: begin
                case (func_code)
                    F_MUL, F_MULH: dec_calc = 1'b1;
                    F_DIV, F_REM: begin
                        if (rs2 == '0)
                            dec_res = (func_code == F_DIV) ? '1 : rs1;
                        else if (rs1 == MOST_NEG && rs2 == '1)
                            dec_res = (func_code == F_DIV) ? rs1 : '0;
                        else
                            dec_calc = 1'b1;
                    end
                    F_DIVU, F_REMU: begin
                        if (rs2 == '0)
                            dec_res = (func_code == F_DIVU) ? '1 : rs1;
                        else
                            dec_calc = 1'b1;
                    end
                    default: dec_ill = 1'b1;
                endcase
            end
`endif
            default: dec_ill = 1'b1;
        endcase
        if (dec_ill) dec_res = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (in_valid) state_d = dec_calc ? CALC : DONE;
            CALC:    if (md_done) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_comb begin
        result_d  = result;
        sign_d    = sign_bits;
        illegal_d = illegal;
        if (state == IDLE && in_valid && !flush && !dec_calc) begin
            result_d  = dec_res;
            sign_d    = sign_of(dec_res);
            illegal_d = dec_ill;
        end else if (state == CALC && md_done && !flush) begin
            result_d  = md_res;
            sign_d    = sign_of(md_res);
            illegal_d = 1'b0;
        end
        out_valid_d = (state_d == DONE);
        in_ready_d  = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            sign_bits <= SGN_ZERO;
            illegal   <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            result    <= result_d;
            sign_bits <= sign_d;
            illegal   <= illegal_d;
            out_valid <= out_valid_d;
            in_ready  <= in_ready_d;
        end
    end

endmodule

// File: tb/tb_scalar_alu_mc.sv
// tb_scalar_alu_mc: randomized self-checking bench for scalar_alu_mc against a behavioural model.
// Builds the MUL/DIV scenarios when SCALAR_ALU_MULDIV_EN is defined.
module tb_scalar_alu_mc;

    localparam logic [3:0] C_MD = 4'd9;
    localparam logic [1:0] S_ZERO = 2'b00, S_POS = 2'b01, S_NEG = 2'b10;
    localparam logic [63:0] MOST_NEG = 64'h8000_0000_0000_0000;

    logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready, illegal;
    logic [63:0] rs1, rs2, imm, result;
    logic [31:0] pc;
    logic [3:0]  alu_signal, func_code;
    logic [1:0]  sign_bits;
    int          checks, errors;

    scalar_alu_mc #(.XLEN(64), .PC_LEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .rs1(rs1), .rs2(rs2), .imm(imm), .pc(pc), .alu_signal(alu_signal), .func_code(func_code),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .sign_bits(sign_bits),
        .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] exp_sign(input logic [63:0] v);
        if (v == 64'd0) return S_ZERO;
        return v[63] ? S_NEG : S_POS;
    endfunction

    // Reference model: plain arithmetic on the op rules; lat = cycles from offer to out_valid.
    function automatic void model(input logic [3:0] s, input logic [3:0] f,
                                  input logic [63:0] a, input logic [63:0] b, input logic [63:0] i,
                                  input logic [31:0] p, output logic [63:0] r, output logic il,
                                  output int lat);
        logic [31:0] w;
        longint sa, sb, si;
        logic signed [127:0] xa, xb, sp;
        r = 64'd0; il = 1'b0; lat = 1; w = 32'd0;
        sa = a; sb = b; si = i;
        case (s)
            4'd0: r = 64'd0;
            4'd1: if (f == 0) r = a + b; else if (f == 1) r = a - b; else il = 1'b1;
            4'd2: begin
                if (f == 0) w = a[31:0] + b[31:0]; else if (f == 1) w = a[31:0] - b[31:0]; else il = 1'b1;
                r = {{32{w[31]}}, w};
            end
            4'd3: if (f == 0) r = a + i; else if (f == 1) r = (sa < si) ? 64'd1 : 64'd0; else il = 1'b1;
            4'd4: begin
                if (f == 0) begin w = a[31:0] + i[31:0]; r = {{32{w[31]}}, w}; end
                else if (f == 1) r = (int'(a[31:0]) < int'(i[31:0])) ? 64'd1 : 64'd0;
                else il = 1'b1;
            end
            4'd5: r = a - b;
            4'd6: r = a + i;
            4'd7: r = {32'd0, p} + i;
            4'd8: r = i;
`ifdef SCALAR_ALU_MULDIV_EN
            4'd9: begin
                xa = sa; xb = sb; sp = xa * xb;
                case (f)
                    4'd0: begin r = sp[63:0];   lat = 65; end
                    4'd1: begin r = sp[127:64]; lat = 65; end
                    4'd2: if (b == 0) r = '1; else if (a == MOST_NEG && b == '1) r = a;
                          else begin r = sa / sb; lat = 65; end
                    4'd3: if (b == 0) r = '1; else begin r = a / b; lat = 65; end
                    4'd4: if (b == 0) r = a; else if (a == MOST_NEG && b == '1) r = 64'd0;
                          else begin r = sa % sb; lat = 65; end
                    4'd5: if (b == 0) r = a; else begin r = a % b; lat = 65; end
                    default: il = 1'b1;
                endcase
            end
`endif
            default: il = 1'b1;
        endcase
        if (il) r = 64'd0;
    endfunction

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return '1;
            2: return MOST_NEG;
            3: return 64'(longint'($urandom_range(0, 40)) - 20);
            4: return {32'd0, $urandom};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Offer one op from IDLE and wait (bounded) for out_valid; lat = -1 on timeout.
    task automatic do_op(input logic [3:0] s, input logic [3:0] f, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] i, input logic [31:0] p,
                         output logic [63:0] r, output logic [1:0] sg, output logic il, output int lat);
        alu_signal = s; func_code = f; rs1 = a; rs2 = b; imm = i; pc = p;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
        r = result; sg = sign_bits; il = illegal;
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        rs1 = 0; rs2 = 0; imm = 0; pc = 0; alu_signal = 0; func_code = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || result !== 64'd0 || sign_bits !== S_ZERO || illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got ov=%b res=%h sign=%b ill=%b, want 0 0 00 0",
                     out_valid, result, sign_bits, illegal);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_vectors();
        logic [63:0] r; logic [1:0] sg; logic il; int lat;
        do_op(4'd1, 4'd0, 64'd5, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 32'd0, r, sg, il, lat);
        checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFD || sg !== S_NEG || lat != 1 || il !== 1'b0) begin
            errors++; $display("FAIL add_neg: got r=%h s=%b lat=%0d il=%b want fffffffffffffffd 10 1 0", r, sg, lat, il);
        end
        retire();
        do_op(4'd2, 4'd0, 64'h7FFF_FFFF, 64'd1, 64'd0, 32'd0, r, sg, il, lat);
        checks++;
        if (r !== 64'hFFFF_FFFF_8000_0000 || sg !== S_NEG || lat != 1) begin
            errors++; $display("FAIL addw_ovf: got r=%h s=%b lat=%0d want ffffffff80000000 10 1", r, sg, lat);
        end
        retire();
        do_op(4'd0, 4'd0, 64'd9, 64'd9, 64'd9, 32'd9, r, sg, il, lat);
        checks++;
        if (r !== 64'd0 || sg !== S_ZERO || il !== 1'b0 || lat != 1) begin
            errors++; $display("FAIL nop: got r=%h s=%b il=%b lat=%0d want 0 00 0 1", r, sg, il, lat);
        end
        retire();
        do_op(4'd7, 4'd0, 64'd0, 64'd0, 64'd16, 32'hFFFF_FFF0, r, sg, il, lat);
        checks++;
        if (r !== 64'h1_0000_0000 || sg !== S_POS) begin
            errors++; $display("FAIL pc_zext: got r=%h s=%b want 100000000 01", r, sg);
        end
        retire();
    endtask

    task automatic test_illegal();
        logic [63:0] r; logic [1:0] sg; logic il; int lat;
        logic [3:0] cls [3] = '{4'd15, 4'd1, 4'd12};
        logic [3:0] fn  [3] = '{4'd0, 4'd7, 4'd3};
        for (int k = 0; k < 3; k++) begin
            do_op(cls[k], fn[k], 64'd3, 64'd4, 64'd5, 32'd6, r, sg, il, lat);
            checks++;
            if (r !== 64'd0 || sg !== S_ZERO || il !== 1'b1 || lat != 1) begin
                errors++; $display("FAIL illegal_%0d: got r=%h s=%b il=%b lat=%0d want 0 00 1 1", k, r, sg, il, lat);
            end
            retire();
        end
    endtask

    task automatic test_random_ops();
        logic [63:0] a, b, i, r, er; logic [1:0] sg; logic il, eil; int lat, elat;
        logic [3:0] s, f; logic [31:0] p;
        for (int n = 0; n < 60; n++) begin
            s = 4'($urandom_range(0, 11));
            if (s == 4'd10) s = 4'd15;
            f = 4'($urandom_range(0, (s == C_MD) ? 7 : 2));
            a = rnd64(); b = rnd64(); i = rnd64(); p = $urandom;
            model(s, f, a, b, i, p, er, eil, elat);
            do_op(s, f, a, b, i, p, r, sg, il, lat);
            checks++;
            if (r !== er || sg !== exp_sign(er) || il !== eil || lat != elat) begin
                errors++;
                $display("FAIL rand_%0d cls=%0d fn=%0d a=%h b=%h i=%h: got r=%h s=%b il=%b lat=%0d want r=%h s=%b il=%b lat=%0d",
                         n, s, f, a, b, i, r, sg, il, lat, er, exp_sign(er), eil, elat);
            end
            retire();
        end
    endtask

    task automatic test_hold();
        logic [63:0] r; logic [1:0] sg; logic il; int lat;
        do_op(4'd5, 4'd0, 64'd100, 64'd30, 64'd0, 32'd0, r, sg, il, lat);
        checks++;
        if (r !== 64'd70 || lat != 1) begin
            errors++; $display("FAIL branch_cond: got r=%h lat=%0d want 46 1", r, lat);
        end
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            checks++;
            if (result !== 64'd70 || sign_bits !== S_POS || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++; $display("FAIL hold_%0d: got r=%h s=%b ov=%b ir=%b want 46 01 1 0",
                                   k, result, sign_bits, out_valid, in_ready);
            end
        end
        // Offer a new op in the retiring cycle; it must not be taken.
        alu_signal = 4'd8; imm = 64'd1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL retire_no_b2b: got ov=%b ir=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_flush();
        logic [63:0] r; logic [1:0] sg; logic il; int lat;
        do_op(4'd6, 4'd0, 64'd1, 64'd0, 64'd2, 32'd0, r, sg, il, lat);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_done: got ov=%b ir=%b want 0 1", out_valid, in_ready);
        end
        alu_signal = 4'd8; imm = 64'd5; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_accept: got ov=%b ir=%b want 0 1", out_valid, in_ready);
        end
    endtask

`ifdef SCALAR_ALU_MULDIV_EN
    task automatic test_muldiv();
        logic [63:0] r; logic [1:0] sg; logic il; int lat;
        bit seen;
        do_op(C_MD, 4'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'd0, 32'd0, r, sg, il, lat);
        checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFEB || lat != 65 || sg !== S_NEG) begin
            errors++; $display("FAIL mul_7x-3: got r=%h lat=%0d s=%b want ffffffffffffffeb 65 10", r, lat, sg);
        end
        retire();
        do_op(C_MD, 4'd2, 64'd7, 64'd0, 64'd0, 32'd0, r, sg, il, lat);
        checks++;
        if (r !== '1 || lat != 1) begin
            errors++; $display("FAIL div_by0: got r=%h lat=%0d want all-ones 1", r, lat);
        end
        retire();
        do_op(C_MD, 4'd4, 64'd7, 64'd0, 64'd0, 32'd0, r, sg, il, lat);
        checks++;
        if (r !== 64'd7 || lat != 1) begin
            errors++; $display("FAIL rem_by0: got r=%h lat=%0d want 7 1", r, lat);
        end
        retire();
        for (int m = 0; m < 2; m++) begin
            alu_signal = C_MD; func_code = 4'd2; rs1 = 64'd100; rs2 = 64'd7; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            repeat (19) @(posedge clk);
            #1;
            if (m == 0) begin
                flush = 1'b1;
                @(posedge clk); #1;
                flush = 1'b0;
            end else begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
            end
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++; $display("FAIL abort_calc_%0d: got ir=%b ov=%b want 1 0", m, in_ready, out_valid);
            end
            seen = 1'b0;
            repeat (80) begin
                @(posedge clk); #1;
                if (out_valid) seen = 1'b1;
            end
            checks++;
            if (seen) begin
                errors++; $display("FAIL abort_no_output_%0d: got out_valid rising want none", m);
            end
        end
    endtask
`else
    task automatic test_muldiv();
        logic [63:0] r; logic [1:0] sg; logic il; int lat;
        for (int k = 0; k < 6; k++) begin
            do_op(C_MD, 4'(k), 64'd7, 64'd3, 64'd0, 32'd0, r, sg, il, lat);
            checks++;
            if (r !== 64'd0 || il !== 1'b1 || sg !== S_ZERO || lat != 1) begin
                errors++; $display("FAIL muldiv_off_%0d: got r=%h il=%b s=%b lat=%0d want 0 1 00 1", k, r, il, sg, lat);
            end
            retire();
        end
    endtask
`endif

    initial begin
        checks = 0; errors = 0;
        test_reset();
        test_vectors();
        test_illegal();
        test_hold();
        test_flush();
        test_muldiv();
        test_random_ops();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
